// File: rtl/aud_rmm_burst.sv
// -----------------------------------------------------------------------------
// aud_rmm_burst
//   Renesas AUD RAM-monitor master with burst support. A host command
//   (address, size, direction, beat count) is turned into one AUD RAM-monitor
//   transaction per beat. Each beat waits for the target's ready nibble, with a
//   bounded busy count, and read data is returned on a separate bus.
//
// Ports
//   aud_ck        clock, rising edge
//   rst           asynchronous active-high reset
//   cmd_*         host command handshake (cmd_ready high only in IDLE)
//   wdata*        write-data handshake (wdata_ready marks the accepting cycle)
//   rdata*        read data, right-aligned, zero-extended; one-cycle valid pulse
//   done          one-cycle pulse at command end (success or abort)
//   err           sticky error, cleared when the next command is accepted
//   idle          FSM in IDLE
//   aud_data      AUD nibble bus, released (hi-Z) unless this block drives it
//   aud_nsync     active-low sync, low while the request is being sent
// -----------------------------------------------------------------------------
module aud_rmm_burst #(
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               aud_ck,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [1:0]         cmd_size,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [31:0]        wdata,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               done,
  output logic               err,
  output logic               idle,
  inout  wire  [3:0]         aud_data,
  output logic               aud_nsync
);

  localparam int         ANIB      = ADDR_W / 4;
  localparam logic [2:0] ADDR_LAST = 3'(ANIB - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WDAT, S_CMD, S_ADDR, S_DOUT, S_TURN, S_WAIT, S_DIN, S_GAP, S_ABORT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               we_q, we_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic [2:0]         cnt_q, cnt_d;     // nibbles left in ADDR/DOUT/DIN, minus 1
  logic [15:0]        busy_q, busy_d;
  logic [27:0]        shift_q, shift_d; // DIN nibbles collected so far
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               oe_q, oe_d;
  logic               nsync_q, nsync_d;
  logic [3:0]         nib_q, nib_d;
  logic [31:0]        addr_ext;

  // Index of the last nibble of a data phase: 2, 4 or 8 nibbles.
  function automatic logic [2:0] last_nib(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    beat_d   = beat_q;
    wbuf_d   = wbuf_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d = cmd_addr;
        size_d = cmd_size;
        we_d   = cmd_we;
        beat_d = cmd_len;
        err_d  = 1'b0;
        if (cmd_size == 2'd3) state_d = S_ABORT;
        else if (cmd_we)      state_d = S_WDAT;
        else                  state_d = S_CMD;
      end
      S_WDAT: if (wdata_valid) begin
        wbuf_d  = wdata;
        state_d = S_CMD;
      end
      S_CMD: begin
        state_d = S_ADDR;
        cnt_d   = ADDR_LAST;
      end
      S_ADDR: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else if (we_q) begin
          state_d = S_DOUT;
          cnt_d   = last_nib(size_q);
        end else state_d = S_TURN;
      end
      S_DOUT: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = S_TURN;
      end
      S_TURN: begin
        state_d = S_WAIT;
        busy_d  = '0;
      end
      S_WAIT: begin
        case (aud_data)
          4'h0: begin
            busy_d = busy_q + 16'd1;
            if ({1'b0, busy_q} + 17'd1 >= 17'(TIMEOUT)) state_d = S_ABORT;
          end
          4'h1: begin
            if (we_q) state_d = S_GAP;
            else begin
              state_d = S_DIN;
              cnt_d   = last_nib(size_q);
              shift_d = '0;
            end
          end
          default: state_d = S_ABORT;
        endcase
      end
      S_DIN: begin
        shift_d = {shift_q[23:0], aud_data};
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else begin
          // Shift register was cleared on entry, so short reads zero-extend.
          rdata_d  = {shift_q, aud_data};
          rvalid_d = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (beat_q == '0) state_d = S_IDLE;
        else begin
          beat_d  = beat_q - 1'b1;
          addr_d  = addr_q + ADDR_W'(32'd1 << size_q);
          state_d = we_q ? S_WDAT : S_CMD;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin-facing outputs are decoded from the next state so they leave flops.
    if (state_d == S_ABORT) err_d = 1'b1;
    done_d   = (state_d == S_ABORT) || ((state_d == S_GAP) && (beat_d == '0));
    oe_d     = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DOUT);
    nsync_d  = !oe_d;
    addr_ext = 32'(addr_d);
    case (state_d)
      S_CMD:   nib_d = {1'b1, we_d, size_d};
      S_ADDR:  nib_d = addr_ext[{cnt_d, 2'b00} +: 4];
      S_DOUT:  nib_d = wbuf_d[{cnt_d, 2'b00} +: 4];
      default: nib_d = 4'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      wbuf_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      oe_q     <= 1'b0;
      nsync_q  <= 1'b1;
      nib_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      wbuf_q   <= wbuf_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      oe_q     <= oe_d;
      nsync_q  <= nsync_d;
      nib_q    <= nib_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign idle        = (state_q == S_IDLE);
  // Handshake qualifier: high only in the cycle the word is actually taken.
  assign wdata_ready = (state_q == S_WDAT) && wdata_valid;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aud_nsync   = nsync_q;
  assign aud_data    = oe_q ? nib_q : 4'bzzzz;

endmodule

// File: tb/tb_aud_rmm_burst.sv
module tb_aud_rmm_burst;

  localparam int TO = 16;

  logic        aud_ck = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [1:0]  cmd_size = '0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        idle;
  tri1  [3:0]  aud_data;   // pulled high: a released bus reads 4'hF
  logic        aud_nsync;
  logic        tb_oe = 1'b0;
  logic [3:0]  tb_nib = '0;

  assign aud_data = tb_oe ? tb_nib : 4'bzzzz;

  aud_rmm_burst #(.ADDR_W(32), .BURST_W(4), .TIMEOUT(TO)) dut (
    .aud_ck(aud_ck), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .idle(idle), .aud_data(aud_data), .aud_nsync(aud_nsync)
  );

  always #5 aud_ck = ~aud_ck;

  // One entry per clock cycle: what the bench drives and what it requires.
  typedef struct {
    bit        cmd_valid;
    bit        cmd_we;
    bit [1:0]  cmd_size;
    bit [31:0] cmd_addr;
    bit [3:0]  cmd_len;
    bit        wdata_valid;
    bit [31:0] wdata;
    bit        tb_drv;
    bit [3:0]  tb_nib;
    bit        idle;
    bit        nsync;
    bit [3:0]  bus;
    bit        wready;
    bit        rvalid;
    bit [31:0] rdata;
    bit        done;
    bit        err;
  } cyc_t;

  cyc_t        trace[$];
  int          p_busy[$];
  bit [3:0]    p_rep[$];    // 0 = target stays busy until timeout
  bit [31:0]   p_data[$];
  int          p_wdly[$];

  bit          m_err;
  bit [31:0]   m_rdata;

  int          n_cmp, n_bad;
  logic [127:0] bus_log;
  int          nsync_lo, rv_cnt, done_cnt, wr_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_log();
    bus_log = '0; nsync_lo = 0; rv_cnt = 0; done_cnt = 0; wr_cnt = 0;
  endtask

  function automatic cyc_t blank(input bit is_idle);
    cyc_t c;
    c.cmd_valid   = is_idle ? 1'b0 : 1'($urandom_range(0, 1));
    c.cmd_we      = 1'($urandom);
    c.cmd_size    = 2'($urandom);
    c.cmd_addr    = $urandom;
    c.cmd_len     = 4'($urandom);
    c.wdata_valid = 1'($urandom);
    c.wdata       = $urandom;
    c.tb_drv      = 1'b0;
    c.tb_nib      = 4'h0;
    c.idle        = is_idle;
    c.nsync       = 1'b1;
    c.bus         = 4'hF;
    c.wready      = 1'b0;
    c.rvalid      = 1'b0;
    c.rdata       = m_rdata;
    c.done        = 1'b0;
    c.err         = m_err;
    return c;
  endfunction

  task automatic plan(input int k, input bit [3:0] rep, input bit [31:0] d, input int w);
    p_busy.push_back(k); p_rep.push_back(rep); p_data.push_back(d); p_wdly.push_back(w);
  endtask

  function automatic cyc_t tgt(input bit [3:0] v);
    cyc_t c;
    c = blank(1'b0);
    c.tb_drv = 1'b1; c.tb_nib = v; c.bus = v;
    return c;
  endfunction

  function automatic cyc_t abort_cyc();
    cyc_t c;
    c = blank(1'b0);
    c.done = 1'b1; c.err = 1'b1;
    return c;
  endfunction

  // Expected cycle timeline of one command, built from the beat timing rules.
  task automatic gen_cmd(input bit we, input bit [1:0] size, input bit [31:0] addr,
                         input bit [3:0] len);
    cyc_t      c;
    int        n, k, w, nidle;
    bit [31:0] a, d, mask;
    bit [3:0]  rep;
    c = blank(1'b1);
    c.cmd_valid = 1'b1; c.cmd_we = we; c.cmd_size = size; c.cmd_addr = addr; c.cmd_len = len;
    trace.push_back(c);
    m_err = 1'b0;
    if (size == 2'd3) begin
      m_err = 1'b1;
      c = blank(1'b0); c.done = 1'b1;
      trace.push_back(c);
    end else begin
      n    = 2 << size;
      mask = (size == 2'd2) ? 32'hFFFF_FFFF : ((32'd1 << (4 * n)) - 32'd1);
      for (int b = 0; b <= int'(len); b++) begin
        a   = addr + (32'(b) << size);
        k   = p_busy.pop_front();
        rep = p_rep.pop_front();
        d   = p_data.pop_front();
        w   = p_wdly.pop_front();
        if (we) begin
          for (int i = 0; i < w; i++) begin
            c = blank(1'b0); c.wdata_valid = 1'b0; trace.push_back(c);
          end
          c = blank(1'b0); c.wdata_valid = 1'b1; c.wdata = d; c.wready = 1'b1;
          trace.push_back(c);
        end
        c = blank(1'b0); c.nsync = 1'b0; c.bus = {1'b1, we, size}; trace.push_back(c);
        for (int i = 7; i >= 0; i--) begin
          c = blank(1'b0); c.nsync = 1'b0; c.bus = a[4*i +: 4]; trace.push_back(c);
        end
        if (we) for (int i = n - 1; i >= 0; i--) begin
          c = blank(1'b0); c.nsync = 1'b0; c.bus = d[4*i +: 4]; trace.push_back(c);
        end
        trace.push_back(blank(1'b0));                 // turnaround
        if (rep == 4'h0) begin
          for (int i = 0; i < TO; i++) trace.push_back(tgt(4'h0));
          trace.push_back(abort_cyc());
          m_err = 1'b1;
          break;
        end
        for (int i = 0; i < k; i++) trace.push_back(tgt(4'h0));
        trace.push_back(tgt(rep));
        if (rep != 4'h1) begin
          trace.push_back(abort_cyc());
          m_err = 1'b1;
          break;
        end
        if (!we) begin
          for (int i = n - 1; i >= 0; i--) trace.push_back(tgt(d[4*i +: 4]));
          m_rdata = d & mask;
        end
        c = blank(1'b0); c.rvalid = !we; c.done = (b == int'(len));
        trace.push_back(c);
      end
    end
    p_busy.delete(); p_rep.delete(); p_data.delete(); p_wdly.delete();
    nidle = $urandom_range(0, 2);
    for (int i = 0; i < nidle; i++) trace.push_back(blank(1'b1));
  endtask

  // Compare process: replay the timeline, checking every output each cycle.
  task automatic run_trace(input int max);
    cyc_t c;
    int   cnt = 0;
    while (trace.size() > 0 && cnt < max) begin
      c = trace.pop_front();
      cnt++;
      @(negedge aud_ck);
      cmd_valid = c.cmd_valid; cmd_we = c.cmd_we; cmd_size = c.cmd_size;
      cmd_addr = c.cmd_addr; cmd_len = c.cmd_len;
      wdata_valid = c.wdata_valid; wdata = c.wdata;
      tb_oe = c.tb_drv; tb_nib = c.tb_nib;
      #1;
      check("idle", idle, c.idle);
      check("cmd_ready", cmd_ready, c.idle);
      check("aud_nsync", aud_nsync, c.nsync);
      check("aud_data", aud_data, c.bus);
      check("wdata_ready", wdata_ready, c.wready);
      check("rdata_valid", rdata_valid, c.rvalid);
      check("rdata", rdata, c.rdata);
      check("done", done, c.done);
      check("err", err, c.err);
      if (aud_nsync == 1'b0) begin
        bus_log = {bus_log[123:0], aud_data};
        nsync_lo++;
      end
      if (rdata_valid) rv_cnt++;
      if (done) done_cnt++;
      if (wdata_ready) wr_cnt++;
    end
  endtask

  initial begin
    bit        we;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [3:0]  len, rep;
    int        r;
    n_cmp = 0; n_bad = 0; m_err = 1'b0; m_rdata = '0;
    clr_log();

    // Reset values
    #1 rst = 1'b1;
    #3;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_nsync", aud_nsync, 1'b1);
    check("rst_bus", aud_data, 4'hF);
    check("rst_wready", wdata_ready, 1'b0);
    check("rst_rvalid", rdata_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge aud_ck);
    rst = 1'b0;

    // Longword write
    clr_log();
    plan(2, 4'h1, 32'h89AB_CDEF, 0);
    gen_cmd(1'b1, 2'd2, 32'h0123_4567, 4'd0);
    run_trace(1 << 30);
    check("lw_write_bus", bus_log, 128'hE0123456789ABCDEF);
    check("lw_write_done", done_cnt, 1);
    check("lw_write_wready", wr_cnt, 1);
    check("lw_write_err", err, 1'b0);

    // Longword read
    clr_log();
    plan(1, 4'h1, 32'h0123_4567, 0);
    gen_cmd(1'b0, 2'd2, 32'h0123_4567, 4'd0);
    run_trace(1 << 30);
    check("lw_read_bus", bus_log, 128'hA01234567);
    check("lw_read_rdata", rdata, 32'h0123_4567);
    check("lw_read_rvalid", rv_cnt, 1);

    // Byte read burst across the address wrap
    clr_log();
    plan(0, 4'h1, 32'h12, 0);
    plan(2, 4'h1, 32'hAB34, 0);
    plan(1, 4'h1, 32'h56, 0);
    gen_cmd(1'b0, 2'd0, 32'hFFFF_FFFF, 4'd2);
    run_trace(1 << 30);
    check("burst_bus", bus_log, 128'h8FFFFFFFF800000000800000001);
    check("burst_rdata", rdata, 32'h56);
    check("burst_rvalid", rv_cnt, 3);
    check("burst_done", done_cnt, 1);

    // Timeout on the first of four beats
    clr_log();
    for (int i = 0; i < 4; i++) plan(0, 4'h0, $urandom, 0);
    gen_cmd(1'b0, 2'd1, 32'h0000_1000, 4'd3);
    run_trace(1 << 30);
    check("to_err", err, 1'b1);
    check("to_done", done_cnt, 1);
    check("to_rvalid", rv_cnt, 0);

    // Accepting a new command clears err
    plan(0, 4'h1, 32'h5A, 1);
    gen_cmd(1'b1, 2'd0, 32'h0000_2000, 4'd0);
    run_trace(1 << 30);
    check("clr_err", err, 1'b0);

    // Bad ready nibble, then illegal size
    clr_log();
    plan(1, 4'h3, 32'h0, 0);
    gen_cmd(1'b0, 2'd2, 32'h0000_3000, 4'd0);
    run_trace(1 << 30);
    check("bad_rdy_err", err, 1'b1);
    clr_log();
    gen_cmd(1'b0, 2'd3, 32'h0000_4000, 4'd0);
    run_trace(1 << 30);
    check("illegal_nsync_lo", nsync_lo, 0);
    check("illegal_done", done_cnt, 1);
    check("illegal_err", err, 1'b1);

    // Randomized commands
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom);
      size = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) size = 2'd3;
      addr = $urandom;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      len = 4'($urandom_range(0, 3));
      for (int b = 0; b <= int'(len); b++) begin
        r   = $urandom_range(0, 15);
        rep = (r == 0) ? 4'h0 : (r == 1) ? 4'($urandom_range(2, 15)) : 4'h1;
        plan($urandom_range(0, 3), rep, $urandom, $urandom_range(0, 2));
      end
      gen_cmd(we, size, addr, len);
      run_trace(1 << 30);
    end

    // Reset in the middle of the address phase
    plan(0, 4'h1, 32'hDEAD_BEEF, 0);
    gen_cmd(1'b0, 2'd2, 32'hCAFE_0000, 4'd0);
    run_trace(1 << 30);
    plan(0, 4'h1, 32'h0, 0);
    gen_cmd(1'b0, 2'd2, 32'h1357_9BDF, 4'd0);
    run_trace(5);                                     // issue, CMD, 3 ADDR cycles
    check("mid_pre_nsync", aud_nsync, 1'b0);
    trace.delete();
    rst = 1'b1;
    #1;
    check("mid_nsync", aud_nsync, 1'b1);
    check("mid_bus", aud_data, 4'hF);
    check("mid_idle", idle, 1'b1);
    check("mid_err", err, 1'b0);
    check("mid_rdata", rdata, 32'h0);
    check("mid_done", done, 1'b0);
    cmd_valid = 1'b0; tb_oe = 1'b0;
    @(negedge aud_ck);
    rst = 1'b0;
    m_err = 1'b0; m_rdata = '0;
    plan(1, 4'h1, 32'h0000_BEEF, 0);
    gen_cmd(1'b0, 2'd1, 32'h0000_0010, 4'd0);
    run_trace(1 << 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aud_rmm_burst.md
# aud_rmm_burst

Parametrised Renesas AUD RAM-monitor master, the successor to `aud_rmm`. It accepts a host-side command of address, size, direction and beat count, and serialises one AUD RAM-monitor transaction per beat onto `aud_data`/`aud_nsync`. Per beat it waits for the target's ready nibble, bounded by a timeout, and returns read data on a separate bus. It sits between the host bridge and the AUD pins, clocked by the AUD clock.

## Interface
- `ADDR_W`, 32: address width. Must be a multiple of 4, range 8..32. `ANIB = ADDR_W/4` address nibbles.
- `BURST_W`, 4: width of `cmd_len`, giving up to 2^BURST_W beats.
- `TIMEOUT`, 64: maximum busy cycles per beat before abort. Range 1..65535.

Ports:
- `aud_ck`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offer.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_size`  in  2  0 = byte, 1 = word, 2 = longword, 3 = illegal.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_len`  in  BURST_W  beats minus 1.
- `wdata`  in  32  write data, right-aligned.
- `wdata_valid`  in  1  write data offer.
- `wdata_ready`  out  1  write data taken this cycle.
- `rdata`  out  32  read data, right-aligned, zero-extended.
- `rdata_valid`  out  1  one-cycle pulse per read beat; no backpressure.
- `done`  out  1  one-cycle pulse at command end, on success or abort.
- `err`  out  1  sticky; cleared when the next command is accepted.
- `idle`  out  1  FSM in IDLE.
- `aud_data`  inout  4  AUD nibble bus; hi-Z when not driven.
- `aud_nsync`  out  1  active-low sync.

## Operation
- Command is accepted on `cmd_valid & cmd_ready`. The block latches addr, size, we, len and sets the beat counter to `len`.
- `cmd_size==3` gives `err=1` and a `done` pulse on the next cycle, then IDLE. The AUD bus is never driven.
- States and transitions:
  - IDLE → WDAT if write, else CMD.
  - WDAT: wait for `wdata_valid`. `wdata_ready` pulses on the accepting cycle, the word is latched, → CMD. The bus stays released with `aud_nsync=1`.
  - CMD: `aud_nsync=0`, drive `{1'b1, we, size}` (longword write = 4'hE, longword read = 4'hA).
  - ADDR: `ANIB` cycles, address nibbles MS first.
  - DOUT (write only): `2<<size` nibbles (2, 4 or 8), MS first.
  - TURN: `aud_nsync=1`, bus released, 1 cycle.
  - WAIT: sample `aud_data` each cycle.
    - 4'h0 = busy: increment busy counter. When the counter reaches `TIMEOUT` → ABORT.
    - 4'h1 = ready: read → DIN; write → GAP.
    - Any other value → ABORT.
  - DIN: sample `2<<size` nibbles MS first into a shift register. After the last nibble, `rdata` updates and `rdata_valid` pulses.
  - GAP: 1 cycle with bus released. If the beat counter is 0, assert `done` → IDLE. Otherwise decrement, add `1<<size` to the address (mod 2^ADDR_W), and go → WDAT/CMD.
  - ABORT: set `err`, pulse `done`, → IDLE. Remaining beats are discarded.
- `aud_nsync` is low only in CMD, ADDR and DOUT. `aud_data` is driven only in those states.
- Unused upper bits of byte and word writes are ignored.

## Timing
- Reset values: `cmd_ready=1`, `idle=1`, `aud_nsync=1`, `aud_data` hi-Z. `wdata_ready`, `rdata_valid`, `done` and `err` are 0. `rdata=0`.
- All outputs are registered, so the bus drive and `aud_nsync` come straight from state flops. The CMD nibble appears the cycle after acceptance (read), or the cycle after the WDAT handshake (write).
- Longword write beat at `ADDR_W=32`: 1 CMD + 8 ADDR + 8 DOUT + 1 TURN + (k+1) WAIT + 1 GAP, where k = busy nibbles.
- Longword read beat: 1 + 8 + 1 + (k+1) + 8 DIN + 1 GAP. `rdata_valid` is asserted on the cycle after the last DIN sample.
- `done` coincides with the final GAP→IDLE cycle. `cmd_ready` returns high the following cycle.
- Reset asserted mid-transaction returns everything to reset values immediately. The bus is released asynchronously.
- `cmd_valid` while not IDLE is ignored; the command is not queued.

## Test plan
- Reset mid-operation: assert `rst` during ADDR → `aud_nsync=1` and `aud_data` hi-Z before the next edge; `idle=1`, `err=0`.
- Longword write, addr 0x01234567, data 0x89ABCDEF:
  - Bus nibbles: E, 0,1,2,3,4,5,6,7, 8,9,A,B,C,D,E,F.
  - Target answers 0, 0, 1 → `done` with `err=0`, exactly one `wdata_ready` pulse.
- Longword read, addr 0x01234567:
  - Bus nibbles: A, 0..7.
  - Target answers 0, 1, then 0,1,...,7 → `rdata=0x01234567` with one `rdata_valid` pulse.
- Byte read burst, `cmd_len=2`, addr 0xFFFFFFFF:
  - Beat addresses FFFFFFFF, 00000000, 00000001 (wrap).
  - Replies 0x12, 0x34, 0x56 → three `rdata_valid` pulses, then one `done`.
- Timeout, `TIMEOUT=16`: target holds 0 → ABORT after 16 busy samples. `err=1`, `done` pulse, remaining beats dropped. `err` clears on the next accepted command.
- Ready nibble 4'h3 → `err`. Then `cmd_size=3` → `err` and `done` with `aud_nsync` never low.
